iiitb_tlc_sensor_qual: RTL and testbench

//  Upstream stage of the traffic light controller. Turns the raw farm-road vehicle loop

---
 rtl/tlc_pkg.sv | 20 ++
 rtl/tlc_sensor_debounce.sv | 52 +++++
 rtl/iiitb_tlc_sensor_qual.sv | 124 ++++++++++++
 tb/tb_iiitb_tlc_sensor_qual.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller front end: light encodings,
// qualifier state type and a saturating counter helper.
package tlc_pkg;

   localparam logic [2:0] LIGHT_RED = 3'b100;
   localparam logic [2:0] LIGHT_YEL = 3'b010;
   localparam logic [2:0] LIGHT_GRN = 3'b001;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAITING = 2'd1,
      ST_REQUEST = 2'd2,
      ST_SERVING = 2'd3
   } qual_state_t;

   function automatic logic [7:0] satInc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/tlc_sensor_debounce.sv
// Two-flop synchroniser and debouncer for the farm-road loop detector; emits a
// one-cycle arrival pulse in the cycle the debounced level goes from 0 to 1.
module tlc_sensor_debounce #(
   parameter int DEB_CYCLES = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic sensorRaw_i,
   output logic arrival_o
);
   import tlc_pkg::*;

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

   logic          s1_q, s2_q;
   logic          deb_q, deb_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mismatch;

   assign mismatch = (s2_q != deb_q);

   // A run of mismatching samples is counted; any agreeing sample restarts it.
   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (mismatch) begin
         if (cnt_q == DEB_LAST) begin
            deb_d = s2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign arrival_o = mismatch && (cnt_q == DEB_LAST) && s2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         deb_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= sensorRaw_i;
         s2_q  <= s1_q;
         deb_q <= deb_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/iiitb_tlc_sensor_qual.sv
// Qualifies the debounced farm-road detector into the controller request C, using
// a vehicle queue count, a first-arrival wait timer and a highway minimum-green timer.
module iiitb_tlc_sensor_qual #(
   parameter int TICK_DIV   = 4,
   parameter int DEB_CYCLES = 3,
   parameter int MIN_VEH    = 2,
   parameter int MAX_WAIT   = 5,
   parameter int MIN_HGREEN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sensor_raw,
   input  logic [2:0] light_highway,
   input  logic [2:0] light_farm,
   output logic       C,
   output logic [7:0] vehicle_count,
   output logic       serving
);
   import tlc_pkg::*;

   localparam int TW = $clog2(TICK_DIV + 1);
   localparam int HW = $clog2(MIN_HGREEN + 1);
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HG_MAX    = HW'(MIN_HGREEN);
   localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
   localparam logic [7:0]    VEH_MIN   = 8'(MIN_VEH);

   logic          arrival;
   logic          tick;
   logic [TW-1:0] tickCnt_q, tickCnt_d;
   logic [HW-1:0] hg_q, hg_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [7:0]    count_q, count_d;
   qual_state_t   state_q, state_d;
   logic          c_q, c_d;

   tlc_sensor_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) uDebounce (
      .clk        (clk),
      .rst        (rst),
      .sensorRaw_i(sensor_raw),
      .arrival_o  (arrival)
   );

   assign tick = (tickCnt_q == TICK_LAST);

   always_comb begin
      tickCnt_d = tick ? '0 : tickCnt_q + 1'b1;
      hg_d      = hg_q;
      if (light_highway != LIGHT_GRN) begin
         hg_d = '0;
      end else if (tick && (hg_q < HG_MAX)) begin
         hg_d = hg_q + 1'b1;
      end
   end

   // Illegal farm encodings match none of the guards below, so they never move the FSM.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      wait_d  = wait_q;
      unique case (state_q)
         ST_IDLE: begin
            if (arrival && ((light_farm == LIGHT_RED) || (light_farm == LIGHT_YEL))) begin
               state_d = ST_WAITING;
               count_d = 8'd1;
               wait_d  = '0;
            end
         end
         ST_WAITING: begin
            if (arrival) begin
               count_d = satInc8(count_q);
            end
            if (tick && (wait_q < WAIT_MAX)) begin
               wait_d = wait_q + 1'b1;
            end
            if (((count_d >= VEH_MIN) || (wait_q >= WAIT_MAX)) && (hg_q >= HG_MAX)) begin
               state_d = ST_REQUEST;
            end
         end
         ST_REQUEST: begin
            if (arrival) begin
               count_d = satInc8(count_q);
            end
            if (light_farm == LIGHT_GRN) begin
               state_d = ST_SERVING;
               count_d = 8'd0;
            end
         end
         ST_SERVING: begin
            if (light_farm == LIGHT_RED) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      c_d = (state_d == ST_REQUEST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tickCnt_q <= '0;
         hg_q      <= '0;
         wait_q    <= '0;
         count_q   <= 8'd0;
         state_q   <= ST_IDLE;
         c_q       <= 1'b0;
      end else begin
         tickCnt_q <= tickCnt_d;
         hg_q      <= hg_d;
         wait_q    <= wait_d;
         count_q   <= count_d;
         state_q   <= state_d;
         c_q       <= c_d;
      end
   end

   assign C             = c_q;
   assign vehicle_count = count_q;
   assign serving       = (state_q == ST_SERVING);

endmodule

// File: tb/tb_iiitb_tlc_sensor_qual.sv
// Directed and randomized bench for the farm-road request qualifier, checked every
// cycle against a behavioural model of the detector, queue and timers.
module tb_iiitb_tlc_sensor_qual;

   localparam int TICK_DIV   = 4;
   localparam int DEB_CYCLES = 3;
   localparam int MIN_VEH    = 2;
   localparam int MAX_WAIT   = 5;
   localparam int MIN_HGREEN = 4;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sensor_raw = 1'b0;
   logic [2:0] light_highway = RED;
   logic [2:0] light_farm = RED;
   logic       C;
   logic [7:0] vehicle_count;
   logic       serving;

   int total = 0;
   int bad = 0;

   iiitb_tlc_sensor_qual #(
      .TICK_DIV  (TICK_DIV),
      .DEB_CYCLES(DEB_CYCLES),
      .MIN_VEH   (MIN_VEH),
      .MAX_WAIT  (MAX_WAIT),
      .MIN_HGREEN(MIN_HGREEN)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sensor_raw   (sensor_raw),
      .light_highway(light_highway),
      .light_farm   (light_farm),
      .C            (C),
      .vehicle_count(vehicle_count),
      .serving      (serving)
   );

   always #5 clk = ~clk;

   // Model: phase 0 idle, 1 queue waiting, 2 requesting, 3 farm road served.
   int mCycle, mPhase, mQueue, mWait, mGreen;
   bit mS1, mS2, mDeb;
   bit mHist [3];

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic void modelStep(input bit rs, input bit r, input logic [2:0] lh,
                                     input logic [2:0] lf);
      bit tick, arr;
      int greenNow, waitNow;
      if (rs) begin
         mCycle = 0; mPhase = 0; mQueue = 0; mWait = 0; mGreen = 0;
         mS1 = 0; mS2 = 0; mDeb = 0;
         foreach (mHist[i]) mHist[i] = 0;
         return;
      end
      tick   = ((mCycle % TICK_DIV) == TICK_DIV - 1);
      mCycle = mCycle + 1;
      // The level changes once the last DEB_CYCLES synchronised samples all disagree with it.
      mHist[2] = mHist[1]; mHist[1] = mHist[0]; mHist[0] = mS2;
      arr = 0;
      if ((mHist[0] != mDeb) && (mHist[1] != mDeb) && (mHist[2] != mDeb)) begin
         arr  = !mDeb;
         mDeb = mHist[0];
      end
      mS2 = mS1;
      mS1 = r;
      greenNow = mGreen;
      if (lh != GRN) mGreen = 0;
      else if (tick) mGreen = imin(mGreen + 1, MIN_HGREEN);
      case (mPhase)
         0: if (arr && (lf == RED || lf == YEL)) begin
               mPhase = 1; mQueue = 1; mWait = 0;
            end
         1: begin
               if (arr) mQueue = imin(mQueue + 1, 255);
               waitNow = mWait;
               if (tick) mWait = imin(mWait + 1, MAX_WAIT);
               if ((mQueue >= MIN_VEH || waitNow >= MAX_WAIT) && greenNow >= MIN_HGREEN)
                  mPhase = 2;
            end
         2: begin
               if (arr) mQueue = imin(mQueue + 1, 255);
               if (lf == GRN) begin
                  mPhase = 3; mQueue = 0;
               end
            end
         default: if (lf == RED) mPhase = 0;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit rs, input bit r, input logic [2:0] lh,
                                input logic [2:0] lf);
      rst = rs;
      sensor_raw = r;
      light_highway = lh;
      light_farm = lf;
      @(posedge clk);
      modelStep(rs, r, lh, lf);
      #1;
      checkOutput("C", {7'd0, C}, {7'd0, (mPhase == 2)});
      checkOutput("vehicle_count", vehicle_count, 8'(mQueue));
      checkOutput("serving", {7'd0, serving}, {7'd0, (mPhase == 3)});
   endtask

   task automatic hold(input int n, input bit r, input logic [2:0] lh, input logic [2:0] lf);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, r, lh, lf);
   endtask

   logic [2:0] lightSet [5] = '{RED, YEL, GRN, 3'b000, 3'b111};

   initial begin
      logic [2:0] rlh, rlf;
      bit rr;

      // Reset held with the detector high.
      applyStimulus(1'b1, 1'b1, GRN, RED);
      applyStimulus(1'b1, 1'b1, GRN, RED);
      checkOutput("reset_C", {7'd0, C}, 8'd0);
      checkOutput("reset_count", vehicle_count, 8'd0);
      checkOutput("reset_serving", {7'd0, serving}, 8'd0);
      hold(8, 1'b0, GRN, RED);
      checkOutput("post_reset_count", vehicle_count, 8'd0);

      // Short glitch, then a clean vehicle.
      hold(2, 1'b1, GRN, RED);
      hold(8, 1'b0, GRN, RED);
      checkOutput("glitch_count", vehicle_count, 8'd0);
      hold(4, 1'b1, GRN, RED);
      checkOutput("arrival_cycle4", vehicle_count, 8'd0);
      hold(1, 1'b1, GRN, RED);
      checkOutput("arrival_cycle5", vehicle_count, 8'd1);
      hold(1, 1'b1, GRN, RED);
      hold(6, 1'b0, GRN, RED);

      // Second vehicle reaches the count trigger.
      hold(5, 1'b1, GRN, RED);
      checkOutput("count_trig_count", vehicle_count, 8'd2);
      checkOutput("count_trig_C", {7'd0, C}, 8'd1);
      hold(1, 1'b1, GRN, RED);
      hold(6, 1'b0, GRN, RED);
      hold(1, 1'b0, RED, GRN);
      checkOutput("serve_C", {7'd0, C}, 8'd0);
      checkOutput("serve_count", vehicle_count, 8'd0);
      checkOutput("serve_flag", {7'd0, serving}, 8'd1);
      hold(2, 1'b0, RED, YEL);
      hold(1, 1'b0, GRN, RED);
      checkOutput("serve_done", {7'd0, serving}, 8'd0);

      // Single vehicle times out.
      hold(24, 1'b0, GRN, RED);
      hold(6, 1'b1, GRN, RED);
      hold(30, 1'b0, GRN, RED);
      checkOutput("timeout_C", {7'd0, C}, 8'd1);
      checkOutput("timeout_count", vehicle_count, 8'd1);
      hold(1, 1'b0, RED, GRN);
      hold(2, 1'b0, GRN, RED);

      // Two vehicles while the highway is not green, then green arrives.
      hold(6, 1'b1, YEL, RED);
      hold(6, 1'b0, YEL, RED);
      hold(6, 1'b1, YEL, RED);
      hold(30, 1'b0, YEL, RED);
      checkOutput("min_green_hold_C", {7'd0, C}, 8'd0);
      hold(24, 1'b0, GRN, RED);
      checkOutput("min_green_C", {7'd0, C}, 8'd1);
      hold(6, 1'b1, GRN, RED);
      hold(6, 1'b0, GRN, RED);
      checkOutput("request_count3", vehicle_count, 8'd3);

      // Mid-operation reset.
      applyStimulus(1'b1, 1'b0, GRN, RED);
      checkOutput("mid_reset_C", {7'd0, C}, 8'd0);
      checkOutput("mid_reset_count", vehicle_count, 8'd0);
      checkOutput("mid_reset_serving", {7'd0, serving}, 8'd0);

      // Queue saturation with the highway red.
      for (int v = 0; v < 256; v++) begin
         hold(6, 1'b1, RED, RED);
         hold(6, 1'b0, RED, RED);
      end
      checkOutput("saturate_count", vehicle_count, 8'd255);
      checkOutput("saturate_C", {7'd0, C}, 8'd0);

      // Randomized traffic, including illegal light encodings.
      applyStimulus(1'b1, 1'b0, GRN, RED);
      rr = 1'b0; rlh = GRN; rlf = RED;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 9) == 0) rr = ~rr;
         if ($urandom_range(0, 39) == 0) rlh = lightSet[$urandom_range(0, 4)];
         if ($urandom_range(0, 39) == 0) rlf = lightSet[$urandom_range(0, 4)];
         applyStimulus($urandom_range(0, 499) == 0, rr, rlh, rlf);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
